// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op encodings, default cycle counts, FSM states.
// Imported by the md unit and by the decode/hazard logic that drives it.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing the full 64-bit HI/LO result.
// Signed division works on magnitudes, so the 0x80000000 / -1 overflow wraps cleanly.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_rs;
  logic [31:0] mag_rt;
  logic [31:0] divisor_s;
  logic [31:0] divisor_u;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  assign mag_rs = rs[31] ? (32'd0 - rs) : rs;
  assign mag_rt = rt[31] ? (32'd0 - rt) : rt;

  // A zero divisor is replaced by one; the result is discarded at commit anyway.
  assign divisor_s = (rt == 32'd0) ? 32'd1 : mag_rt;
  assign divisor_u = (rt == 32'd0) ? 32'd1 : rt;

  assign quo_mag = mag_rs / divisor_s;
  assign rem_mag = mag_rs % divisor_s;
  assign quo_u   = rs / divisor_u;
  assign rem_u   = rs % divisor_u;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_lo      = (rs[31] ^ rt[31]) ? (32'd0 - quo_mag) : quo_mag;
        res_hi      = rs[31] ? (32'd0 - rem_mag) : rem_mag;
        div_by_zero = (rt == 32'd0);
      end
      OP_DIVU: begin
        res_lo      = quo_u;
        res_hi      = rem_u;
        div_by_zero = (rt == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: latches the result on accept, holds busy for N cycles, then commits.
// Starts arriving while busy are dropped; MTHI/MTLO write in zero cycles from IDLE.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  md_state_e   state;
  md_state_e   next_state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;
  logic        accept;
  logic        done;

  md_calc u_calc (
    .op          (op),
    .rs          (rs_data),
    .rt          (rt_data),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  assign accept = (state == S_IDLE) && start && is_long_op(op);
  assign done   = (state == S_RUN) && (cnt == '0);
  assign busy   = (state == S_RUN);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = S_RUN;
      S_RUN:  if (done)   next_state = S_IDLE;
      default:            next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_dz <= div_by_zero;
        cnt     <= is_div_op(op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
      end else if (start && op == OP_MTHI) begin
        hi <= rs_data;
      end else if (start && op == OP_MTLO) begin
        lo <= rs_data;
      end
    end else begin
      if (done) begin
        // Divide by zero leaves the architectural HI/LO untouched.
        if (!pend_dz) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic results, busy timing, MT writes,
// divide by zero, ignored starts while busy and asynchronous reset mid-operation.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one instruction for exactly one rising edge; returns just after that edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = OP_NONE;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = OP_NONE; rs_data = 32'd0; rt_data = 32'd0;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult;
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy[%0d]: got %b want 1", i, busy); end
      total++; if (hi !== 32'd0 || lo !== 32'd0) begin
        bad++; $display("FAIL mult_hold[%0d]: got %h_%h want 0_0", i, hi, lo);
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mult_done_busy: got %b want 0", busy); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo: got %h want fffffff1", lo); end
  endtask

  task automatic test_multu;
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
        bad++; $display("FAIL multu_run[%0d]: got %b %h_%h want 1 ffffffff_fffffff1", i, busy, hi, lo);
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL multu_done_busy: got %b want 0", busy); end
    total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi: got %h want 00000001", hi); end
    total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div;
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
        bad++; $display("FAIL div_run[%0d]: got %b %h_%h want 1 00000001_fffffffe", i, busy, hi, lo);
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL div_done_busy: got %b want 0", busy); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end

    launch(OP_DIVU, 32'd7, 32'd2);
    repeat (11) @(negedge clk);
    total++; if (lo !== 32'd3 || hi !== 32'd1) begin
      bad++; $display("FAIL divu: got hi=%h lo=%h want hi=00000001 lo=00000003", hi, lo);
    end

    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL div_ovf_busy_last: got %b want 1", busy); end
    @(negedge clk);
    total++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      bad++; $display("FAIL div_ovf: got hi=%h lo=%h want hi=00000000 lo=80000000", hi, lo);
    end
  endtask

  task automatic test_back_to_back_mt;
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; rs_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    total++; if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
      bad++; $display("FAIL mthi: got busy=%b hi=%h want busy=0 hi=12345678", busy, hi);
    end
    op = OP_MTLO; rs_data = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_NONE;
    total++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      bad++; $display("FAIL mtlo: got busy=%b hi=%h lo=%h want busy=0 hi=12345678 lo=9abcdef0", busy, hi, lo);
    end
  endtask

  task automatic test_div_zero;
    launch(OP_MTHI, 32'h0000_AAAA, 32'd0);
    launch(OP_MTLO, 32'h0000_5555, 32'd0);
    launch(OP_DIVU, 32'd7, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1 || hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
        bad++; $display("FAIL dz_run[%0d]: got %b %h_%h want 1 0000aaaa_00005555", i, busy, hi, lo);
      end
      if (i == 3) begin
        start = 1'b1; op = OP_MULT; rs_data = 32'd3; rt_data = 32'd4;
      end else begin
        start = 1'b0; op = OP_NONE;
      end
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_done_busy: got %b want 0", busy); end
    total++; if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
      bad++; $display("FAIL dz_keep: got hi=%h lo=%h want hi=0000aaaa lo=00005555", hi, lo);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0 || lo !== 32'h0000_5555) begin
        bad++; $display("FAIL dz_ignored_start[%0d]: got busy=%b lo=%h want busy=0 lo=00005555", i, busy, lo);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    launch(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        bad++; $display("FAIL no_commit[%0d]: got busy=%b hi=%h lo=%h want 0 0 0", i, busy, hi, lo);
      end
    end
    launch(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    total++; if (lo !== 32'h0BAD_F00D || hi !== 32'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mtlo_after_reset: got busy=%b hi=%h lo=%h want 0 0 0badf00d", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_back_to_back_mt;
    test_div_zero;
    test_reset_mid_op;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
